// File: rtl/keypad_pkg.sv
// Shared types and key-code constants for the keypad request path.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [KEY_W-1:0] CLEAR_KEY_DEF = 4'hE;
  localparam logic [KEY_W-1:0] ESTOP_KEY_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    WAIT_REL
  } key_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with flush; head word is presented directly from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign w_pop  = i_pop && o_valid && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_request_queue.sv
// Qualifies keypad strokes and turns them into queued floor requests, flushes or e-stops.
module key_request_queue
  import keypad_pkg::*;
#(
  parameter int unsigned      NUM_FLOORS   = 8,
  parameter int unsigned      DEPTH        = 8,
  parameter int unsigned      HOLD_CYCLES  = 4,
  parameter logic             PRESS_ACTIVE = 1'b0,
  parameter logic [KEY_W-1:0] CLEAR_KEY    = CLEAR_KEY_DEF,
  parameter logic [KEY_W-1:0] ESTOP_KEY    = ESTOP_KEY_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_W-1:0]              buttonBus,
  input  logic                          pressed,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [$clog2(NUM_FLOORS)-1:0] req_floor,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          overflow,
  output logic                          estop
);

  localparam int unsigned FW = $clog2(NUM_FLOORS);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  key_state_t            r_state;
  key_state_t            w_state_d;
  logic [KEY_W-1:0]      r_code;
  logic [KEY_W-1:0]      w_code_d;
  logic [HW-1:0]         r_hold;
  logic [HW-1:0]         w_hold_d;
  logic                  w_key_down;
  logic                  w_accept;

  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_overflow;
  logic                  r_estop;

  logic                  w_is_floor;
  logic [FW-1:0]         w_floor_idx;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_dup;
  logic                  w_push;
  logic                  w_drop;
  logic [NUM_FLOORS-1:0] w_pop_mask;
  logic [NUM_FLOORS-1:0] w_push_mask;
  logic [NUM_FLOORS-1:0] w_pend_eff;

  assign w_key_down = (pressed == PRESS_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_d;
      r_code  <= w_code_d;
      r_hold  <= w_hold_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_hold_d  = r_hold;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_key_down) begin
          w_state_d = QUALIFY;
          w_code_d  = buttonBus;
          w_hold_d  = HW'(1);
        end
      end
      QUALIFY: begin
        if (!w_key_down) begin
          w_state_d = IDLE;
          w_hold_d  = '0;
        end else if (buttonBus != r_code) begin
          w_code_d = buttonBus;
          w_hold_d = HW'(1);
        end else if (r_hold == HW'(HOLD_CYCLES)) begin
          w_accept  = 1'b1;
          w_state_d = WAIT_REL;
        end else begin
          w_hold_d = r_hold + HW'(1);
        end
      end
      WAIT_REL: begin
        if (!w_key_down) begin
          w_state_d = IDLE;
          w_hold_d  = '0;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_hold_d  = '0;
      end
    endcase
  end

  assign w_is_floor  = (32'(r_code) < NUM_FLOORS);
  assign w_floor_idx = r_code[FW-1:0];
  assign w_pop       = req_valid && req_ready;
  assign w_flush     = w_accept && (r_code == CLEAR_KEY);

  // A floor leaving the queue this edge no longer counts as pending for a re-press.
  assign w_pop_mask  = w_pop ? (NUM_FLOORS'(1) << req_floor) : '0;
  assign w_pend_eff  = r_pending & ~w_pop_mask;

  assign w_dup       = w_pend_eff[w_floor_idx];
  assign w_push      = w_accept && w_is_floor && !w_dup && (!full || w_pop);
  assign w_drop      = w_accept && w_is_floor && !w_dup && full && !w_pop;
  assign w_push_mask = w_push ? (NUM_FLOORS'(1) << w_floor_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_estop    <= 1'b0;
    end else begin
      r_pending  <= w_flush ? '0 : (w_pend_eff | w_push_mask);
      r_overflow <= w_drop;
      r_estop    <= w_accept && (r_code == ESTOP_KEY);
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_floor_idx),
    .o_data  (req_floor),
    .o_valid (req_valid),
    .o_count (count),
    .o_full  (full)
  );

  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign estop    = r_estop;

endmodule

// File: tb/tb_key_request_queue.sv
// Directed bench for key_request_queue: two instances (DEPTH 8 and 4) checked against a queue model.
module tb_key_request_queue;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pressed;
  logic       ready;
  logic [3:0] bus;

  logic       a_valid, a_full, a_ovf, a_est;
  logic [2:0] a_floor;
  logic [7:0] a_pend;
  logic [3:0] a_count;

  logic       b_valid, b_full, b_ovf, b_est;
  logic [2:0] b_floor;
  logic [7:0] b_pend;
  logic [2:0] b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_request_queue #(
    .NUM_FLOORS   (8),
    .DEPTH        (8),
    .HOLD_CYCLES  (HOLD),
    .PRESS_ACTIVE (1'b0),
    .CLEAR_KEY    (4'hE),
    .ESTOP_KEY    (4'hF)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .buttonBus (bus),
    .pressed   (pressed),
    .req_valid (a_valid),
    .req_ready (ready),
    .req_floor (a_floor),
    .pending   (a_pend),
    .count     (a_count),
    .full      (a_full),
    .overflow  (a_ovf),
    .estop     (a_est)
  );

  key_request_queue #(
    .NUM_FLOORS   (8),
    .DEPTH        (4),
    .HOLD_CYCLES  (HOLD),
    .PRESS_ACTIVE (1'b0),
    .CLEAR_KEY    (4'hE),
    .ESTOP_KEY    (4'hF)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .buttonBus (bus),
    .pressed   (pressed),
    .req_valid (b_valid),
    .req_ready (ready),
    .req_floor (b_floor),
    .pending   (b_pend),
    .count     (b_count),
    .full      (b_full),
    .overflow  (b_ovf),
    .estop     (b_est)
  );

  // Model: stroke tracked as a run of identical key-down samples; queue as a plain array.
  int mq [2][16];
  int msz [2];
  bit movf [2];
  bit mest [2];
  bit mvalid = 1'b0;
  int run = 0;
  int last = 0;
  bit used = 1'b0;
  bit acc;
  bit mpop;
  bit hit;
  int code;

  function automatic int dep(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mvalid = 1'b1;
      run    = 0;
      used   = 1'b0;
      for (int i = 0; i < 2; i++) begin
        msz[i] = 0; movf[i] = 1'b0; mest[i] = 1'b0;
      end
    end else begin
      acc  = 1'b0;
      code = int'(bus);
      if (pressed != 1'b0) begin
        run  = 0;
        used = 1'b0;
      end else begin
        run  = (run > 0 && code == last) ? run + 1 : 1;
        last = code;
        if (!used && run >= HOLD + 1) begin
          acc  = 1'b1;
          used = 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        movf[i] = 1'b0;
        mest[i] = 1'b0;
        mpop    = (msz[i] > 0) && ready;
        if (acc && code == 14) begin
          msz[i] = 0;
        end else begin
          if (mpop) begin
            for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
            msz[i]--;
          end
          if (acc && code < 8) begin
            hit = 1'b0;
            for (int k = 0; k < msz[i]; k++) if (mq[i][k] == code) hit = 1'b1;
            if (!hit) begin
              if (msz[i] == dep(i)) movf[i] = 1'b1;
              else begin
                mq[i][msz[i]] = code;
                msz[i]++;
              end
            end
          end
          if (acc && code == 15) mest[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic v, input logic [2:0] f, input logic [7:0] p,
                          input logic [3:0] c, input logic fu, input logic o, input logic e);
    logic [7:0] ep;
    string      pfx;
    pfx = (i == 0) ? "A" : "B";
    ep  = '0;
    for (int k = 0; k < msz[i]; k++) ep[mq[i][k]] = 1'b1;
    chk({pfx, ".req_valid"}, 32'(v), 32'(msz[i] > 0));
    chk({pfx, ".req_floor"}, 32'(f), (msz[i] > 0) ? mq[i][0] : 0);
    chk({pfx, ".pending"}, 32'(p), 32'(ep));
    chk({pfx, ".count"}, 32'(c), msz[i]);
    chk({pfx, ".full"}, 32'(fu), 32'(msz[i] == dep(i)));
    chk({pfx, ".overflow"}, 32'(o), 32'(movf[i]));
    chk({pfx, ".estop"}, 32'(e), 32'(mest[i]));
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp_inst(0, a_valid, a_floor, a_pend, a_count, a_full, a_ovf, a_est);
      cmp_inst(1, b_valid, b_floor, b_pend, {1'b0, b_count}, b_full, b_ovf, b_est);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [3:0] c, input int n);
    pressed = 1'b0;
    bus     = c;
    step(n);
    pressed = 1'b1;
    step(1);
  endtask

  // Hold key c until the cycle before acceptance, then raise ready for the accept edge only.
  task automatic press_pop(input logic [3:0] c);
    pressed = 1'b0;
    bus     = c;
    step(HOLD);
    ready = 1'b1;
    step(1);
  endtask

  task automatic release_key();
    ready   = 1'b0;
    pressed = 1'b1;
    step(1);
  endtask

  initial begin
    rst = 1'b0; pressed = 1'b1; bus = 4'd0; ready = 1'b0;

    // Reset with key 3 held
    pressed = 1'b0; bus = 4'd3;
    step(3);
    chk("rst.valid", 32'(a_valid), 0);
    chk("rst.count", 32'(a_count), 0);
    chk("rst.pending", 32'(a_pend), 0);
    chk("rst.floor", 32'(a_floor), 0);
    chk("rst.full", 32'(b_full), 0);
    rst = 1'b1;
    step(2);
    chk("requal.count", 32'(a_count), 0);
    step(3);
    chk("accept.valid", 32'(a_valid), 1);
    chk("accept.floor", 32'(a_floor), 3);
    chk("accept.pending", 32'(a_pend), 32'h08);
    step(20);
    chk("hold.count", 32'(a_count), 1);
    pressed = 1'b1; ready = 1'b1;
    step(1);
    chk("pop.count", 32'(a_count), 0);
    chk("pop.pending", 32'(a_pend), 0);
    ready = 1'b0;

    // Order and duplicate suppression
    press(4'd2, 5);
    press(4'd5, 5);
    press(4'd2, 5);
    chk("dup.count", 32'(a_count), 2);
    chk("dup.floor", 32'(a_floor), 2);
    chk("dup.pending", 32'(a_pend), 32'h24);
    press(4'd6, 3);
    chk("short.count", 32'(a_count), 2);
    ready = 1'b1;
    step(1);
    chk("order.floor", 32'(a_floor), 5);
    step(1);
    chk("drain.count", 32'(a_count), 0);
    ready = 1'b0;

    // Fill, overflow on the shallow instance, push+pop when full
    for (int f = 0; f < 4; f++) press(4'(f), 5);
    chk("b.full", 32'(b_full), 1);
    pressed = 1'b0; bus = 4'd4;
    step(5);
    chk("b.ovf.pulse", 32'(b_ovf), 1);
    chk("a.count5", 32'(a_count), 5);
    step(1);
    chk("b.ovf.end", 32'(b_ovf), 0);
    pressed = 1'b1;
    step(1);
    for (int f = 5; f < 8; f++) press(4'(f), 5);
    chk("a.full", 32'(a_full), 1);
    chk("a.pend.all", 32'(a_pend), 32'hFF);
    press(4'd0, 5);
    chk("a.dup0", 32'(a_count), 8);
    press_pop(4'd5);
    chk("b.pushpop.count", 32'(b_count), 4);
    chk("b.pushpop.floor", 32'(b_floor), 1);
    chk("a.dup.pop.count", 32'(a_count), 7);
    release_key();
    press_pop(4'd1);
    chk("b.repress.pend", 32'(b_pend), 32'h2E);
    chk("b.repress.floor", 32'(b_floor), 2);
    chk("a.repress.count", 32'(a_count), 7);
    release_key();

    // Clear wins over same-cycle pop
    press_pop(4'hE);
    chk("clr.count", 32'(a_count), 0);
    chk("clr.bcount", 32'(b_count), 0);
    release_key();
    press(4'd1, 5);
    press(4'd4, 5);
    chk("q14.count", 32'(a_count), 2);
    press_pop(4'hE);
    chk("clr2.count", 32'(a_count), 0);
    chk("clr2.pending", 32'(a_pend), 0);
    chk("clr2.valid", 32'(a_valid), 0);
    release_key();

    // Emergency stop pulse and code switch during qualification
    press(4'd1, 5);
    pressed = 1'b0; bus = 4'hF;
    step(5);
    chk("estop.pulse", 32'(a_est), 1);
    chk("estop.count", 32'(a_count), 1);
    step(1);
    chk("estop.end", 32'(a_est), 0);
    pressed = 1'b1;
    step(1);
    pressed = 1'b0; bus = 4'd3;
    step(2);
    bus = 4'd7;
    step(4);
    chk("switch.early", 32'(a_count), 1);
    step(1);
    chk("switch.count", 32'(a_count), 2);
    chk("switch.pending", 32'(a_pend), 32'h82);
    pressed = 1'b1; ready = 1'b1;
    step(1);
    chk("switch.floor", 32'(a_floor), 7);
    step(1);
    chk("switch.drain", 32'(a_count), 0);
    ready = 1'b0;

    // Reset mid-operation discards the queue
    press(4'd2, 5);
    rst = 1'b0;
    step(1);
    chk("midrst.count", 32'(a_count), 0);
    chk("midrst.valid", 32'(a_valid), 0);
    rst = 1'b1;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
